// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the execute stage: instruction codes, ALU and
// condition function codes, the "no register" ID and condition-code bit layout.
package y86_pkg;

  typedef enum logic [3:0] {
    I_HALT   = 4'h0,
    I_NOP    = 4'h1,
    I_RRMOVQ = 4'h2,
    I_IRMOVQ = 4'h3,
    I_RMMOVQ = 4'h4,
    I_MRMOVQ = 4'h5,
    I_OPQ    = 4'h6,
    I_JXX    = 4'h7,
    I_CALL   = 4'h8,
    I_RET    = 4'h9,
    I_PUSHQ  = 4'hA,
    I_POPQ   = 4'hB
  } icode_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'h0,
    ALU_SUB = 4'h1,
    ALU_AND = 4'h2,
    ALU_XOR = 4'h3
  } alufn_e;

  typedef enum logic [3:0] {
    C_YES = 4'h0,
    C_LE  = 4'h1,
    C_L   = 4'h2,
    C_E   = 4'h3,
    C_NE  = 4'h4,
    C_GE  = 4'h5,
    C_G   = 4'h6
  } condfn_e;

  localparam logic [3:0] RNONE = 4'hF;

  // cc is packed as {zf, sf, of}
  localparam int unsigned CC_ZF = 2;
  localparam int unsigned CC_SF = 1;
  localparam int unsigned CC_OF = 0;

  localparam logic [2:0] CC_RESET_DEFAULT = 3'b100;

endpackage

// File: rtl/y86_cond.sv
// Branch / conditional-move condition evaluation from the {zf,sf,of} flags.
module y86_cond
  import y86_pkg::*;
(
  input  logic [2:0] cc,
  input  logic [3:0] ifun,
  output logic       cnd
);

  logic zf, sf, of;

  assign zf = cc[CC_ZF];
  assign sf = cc[CC_SF];
  assign of = cc[CC_OF];

  always_comb begin
    cnd = 1'b0;
    case (ifun)
      C_YES:   cnd = 1'b1;
      C_LE:    cnd = (sf ^ of) | zf;
      C_L:     cnd = sf ^ of;
      C_E:     cnd = zf;
      C_NE:    cnd = !zf;
      C_GE:    cnd = !(sf ^ of);
      C_G:     cnd = !(sf ^ of) && !zf;
      default: cnd = 1'b0;
    endcase
  end

endmodule

// File: rtl/pipe_execute.sv
// Y86 execute stage: ALU, condition-code register and a one-deep output
// register with a valid/ready handshake on both sides.
module pipe_execute
  import y86_pkg::*;
#(
  parameter int unsigned WIDTH    = 64,
  parameter logic [2:0]  CC_RESET = CC_RESET_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       icode,
  input  logic [3:0]       ifun,
  input  logic [WIDTH-1:0] valA,
  input  logic [WIDTH-1:0] valB,
  input  logic [WIDTH-1:0] valC,
  input  logic [3:0]       dstE,
  input  logic [3:0]       dstM,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_icode,
  output logic [WIDTH-1:0] out_valE,
  output logic [WIDTH-1:0] out_valA,
  output logic [3:0]       out_dstE,
  output logic [3:0]       out_dstM,
  output logic             out_cnd,
  output logic             out_err,
  output logic [2:0]       cc
);

  localparam logic [WIDTH-1:0] STACK_STEP = WIDTH'(WIDTH / 8);

  logic             accept;
  logic             err;
  logic             cond_hit;
  logic             cnd;
  logic [WIDTH-1:0] alu_res;
  logic             alu_of;
  logic [WIDTH-1:0] val_e;
  logic [3:0]       dst_e;
  logic [2:0]       cc_q;
  logic [2:0]       cc_next;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;
  assign cc       = cc_q;

  assign err = (icode > 4'hB)
            || (icode == I_OPQ && ifun > 4'd3)
            || ((icode == I_RRMOVQ || icode == I_JXX) && ifun > 4'd6);

  // Condition is taken from the registered flags, i.e. the value before the
  // accepting edge, which already includes an OPq accepted on the prior edge.
  y86_cond u_cond (
    .cc   (cc_q),
    .ifun (ifun),
    .cnd  (cond_hit)
  );

  assign cnd = !err && (icode == I_RRMOVQ || icode == I_JXX) && cond_hit;

  always_comb begin
    alu_res = '0;
    alu_of  = 1'b0;
    case (ifun)
      ALU_ADD: begin
        alu_res = valB + valA;
        alu_of  = (valA[WIDTH-1] == valB[WIDTH-1]) && (alu_res[WIDTH-1] != valB[WIDTH-1]);
      end
      ALU_SUB: begin
        alu_res = valB - valA;
        alu_of  = (valA[WIDTH-1] != valB[WIDTH-1]) && (alu_res[WIDTH-1] != valB[WIDTH-1]);
      end
      ALU_AND: alu_res = valB & valA;
      ALU_XOR: alu_res = valB ^ valA;
      default: alu_res = '0;
    endcase
  end

  assign cc_next = {(alu_res == '0), alu_res[WIDTH-1], alu_of};

  always_comb begin
    val_e = '0;
    if (!err) begin
      case (icode)
        I_RRMOVQ:          val_e = valA;
        I_IRMOVQ:          val_e = valC;
        I_RMMOVQ, I_MRMOVQ: val_e = valB + valC;
        I_OPQ:             val_e = alu_res;
        I_CALL, I_PUSHQ:   val_e = valB - STACK_STEP;
        I_RET, I_POPQ:     val_e = valB + STACK_STEP;
        default:           val_e = '0;
      endcase
    end
  end

  always_comb begin
    dst_e = dstE;
    if (err || (icode == I_RRMOVQ && !cnd)) dst_e = RNONE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_icode <= I_NOP;
      out_valE  <= '0;
      out_valA  <= '0;
      out_dstE  <= RNONE;
      out_dstM  <= RNONE;
      out_cnd   <= 1'b0;
      out_err   <= 1'b0;
      cc_q      <= CC_RESET;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_icode <= icode;
      out_valE  <= val_e;
      out_valA  <= valA;
      out_dstE  <= dst_e;
      out_dstM  <= dstM;
      out_cnd   <= cnd;
      out_err   <= err;
      if (icode == I_OPQ && !err) cc_q <= cc_next;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pipe_execute.sv
// Self-checking bench for pipe_execute: directed scenarios plus a randomized
// run against an arithmetic reference model, on 64- and 32-bit instances.
module tb_pipe_execute;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, flush, out_ready;
  logic [3:0]  icode, ifun, dstE, dstM;
  logic [63:0] valA, valB, valC;

  logic        in_ready64, out_valid64, out_cnd64, out_err64;
  logic [3:0]  out_icode64, out_dstE64, out_dstM64;
  logic [63:0] out_valE64, out_valA64;
  logic [2:0]  cc64;

  logic        in_ready32, out_valid32, out_cnd32, out_err32;
  logic [3:0]  out_icode32, out_dstE32, out_dstM32;
  logic [31:0] out_valE32, out_valA32;
  logic [2:0]  cc32;

  int tests = 0;
  int fails = 0;

  pipe_execute #(.WIDTH(64), .CC_RESET(3'b100)) d64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
    .icode(icode), .ifun(ifun), .valA(valA), .valB(valB), .valC(valC),
    .dstE(dstE), .dstM(dstM), .flush(flush), .out_valid(out_valid64),
    .out_ready(out_ready), .out_icode(out_icode64), .out_valE(out_valE64),
    .out_valA(out_valA64), .out_dstE(out_dstE64), .out_dstM(out_dstM64),
    .out_cnd(out_cnd64), .out_err(out_err64), .cc(cc64)
  );

  pipe_execute #(.WIDTH(32), .CC_RESET(3'b100)) d32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
    .icode(icode), .ifun(ifun), .valA(valA[31:0]), .valB(valB[31:0]), .valC(valC[31:0]),
    .dstE(dstE), .dstM(dstM), .flush(flush), .out_valid(out_valid32),
    .out_ready(out_ready), .out_icode(out_icode32), .out_valE(out_valE32),
    .out_valA(out_valA32), .out_dstE(out_dstE32), .out_dstM(out_dstM32),
    .out_cnd(out_cnd32), .out_err(out_err32), .cc(cc32)
  );

  typedef struct packed {
    logic [3:0]  icode;
    logic [63:0] valE;
    logic [63:0] valA;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic        cnd;
    logic        err;
  } out_t;

  typedef struct packed {
    out_t       o;
    logic [2:0] cc;
  } exp_t;

  // ---------------- reference model ----------------
  function automatic logic signed [66:0] sx(int w, logic [63:0] v);
    logic signed [66:0] r;
    r = $signed({3'b000, v});
    if (v[w-1]) r = r - (67'sd1 <<< w);
    return r;
  endfunction

  function automatic exp_t model(int w, logic [3:0] ic, logic [3:0] fn,
                                 logic [63:0] a_in, logic [63:0] b_in, logic [63:0] c_in,
                                 logic [3:0] de, logic [3:0] dm, logic [2:0] cc_in);
    exp_t e;
    logic [63:0] mask, a, b, c, res;
    logic signed [66:0] exact, hi, lo;
    logic zf, sf, of, ofv, ok;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    a = a_in & mask; b = b_in & mask; c = c_in & mask;
    hi = (67'sd1 <<< (w - 1)) - 67'sd1;
    lo = -(67'sd1 <<< (w - 1));
    zf = cc_in[2]; sf = cc_in[1]; of = cc_in[0];
    e.cc = cc_in;
    e.o.icode = ic; e.o.valA = a; e.o.dstM = dm;
    e.o.valE = 64'd0; e.o.cnd = 1'b0; e.o.dstE = 4'hF;
    e.o.err = (ic > 4'hB) || (ic == 4'h6 && fn > 4'd3) || ((ic == 4'h2 || ic == 4'h7) && fn > 4'd6);
    if (!e.o.err) begin
      case (ic)
        4'h2: e.o.valE = a;
        4'h3: e.o.valE = c;
        4'h4, 4'h5: e.o.valE = b + c;
        4'h8, 4'hA: e.o.valE = b - 64'(w / 8);
        4'h9, 4'hB: e.o.valE = b + 64'(w / 8);
        4'h6: begin
          ofv = 1'b0;
          res = 64'd0;
          case (fn)
            4'd0: begin exact = sx(w, b) + sx(w, a); res = (b + a) & mask; ofv = (exact > hi) || (exact < lo); end
            4'd1: begin exact = sx(w, b) - sx(w, a); res = (b - a) & mask; ofv = (exact > hi) || (exact < lo); end
            4'd2: res = b & a;
            default: res = b ^ a;
          endcase
          e.o.valE = res;
          e.cc = {res == 64'd0, res[w-1], ofv};
        end
        default: e.o.valE = 64'd0;
      endcase
      ok = 1'b0;
      case (fn)
        4'd0: ok = 1'b1;
        4'd1: ok = (sf ^ of) | zf;
        4'd2: ok = sf ^ of;
        4'd3: ok = zf;
        4'd4: ok = !zf;
        4'd5: ok = !(sf ^ of);
        default: ok = !(sf ^ of) && !zf;
      endcase
      e.o.cnd = (ic == 4'h2 || ic == 4'h7) && ok;
      e.o.dstE = (ic == 4'h2 && !e.o.cnd) ? 4'hF : de;
    end
    e.o.valE = e.o.valE & mask;
    return e;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] c,
                       input logic [3:0] de, input logic [3:0] dm);
    icode = ic; ifun = fn; valA = a; valB = b; valC = c; dstE = de; dstM = dm;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [63:0] rand_op();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return 64'd1;
      2: return 64'hFFFF_FFFF_FFFF_FFFF;
      3: return 64'h7FFF_FFFF_FFFF_FFFF;
      4: return 64'h8000_0000_0000_0000;
      5: return 64'h0000_0000_7FFF_FFFF;
      6: return 64'h0000_0000_8000_0000;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(4'h6, 4'h0, 64'd3, 64'd4, 64'd0, 4'h2, 4'h3);
    tick();
    tests++;
    if ({out_valid64, out_icode64, out_valE64, out_valA64, out_dstE64, out_dstM64, out_cnd64, out_err64, cc64}
        !== {1'b0, 4'h1, 64'd0, 64'd0, 4'hF, 4'hF, 1'b0, 1'b0, 3'b100}) begin
      fails++;
      $display("FAIL reset64: valid=%b icode=%h valE=%h valA=%h dstE=%h dstM=%h cnd=%b err=%b cc=%b, required 0 1 0 0 F F 0 0 100",
               out_valid64, out_icode64, out_valE64, out_valA64, out_dstE64, out_dstM64, out_cnd64, out_err64, cc64);
    end
    tests++;
    if ({out_valid32, cc32, in_ready32} !== {1'b0, 3'b100, 1'b1}) begin
      fails++;
      $display("FAIL reset32: valid=%b cc=%b in_ready=%b, required 0 100 1", out_valid32, cc32, in_ready32);
    end
    rst_n = 1'b1; in_valid = 1'b0;
  endtask

  task automatic test_add_overflow();
    in_valid = 1'b1; out_ready = 1'b1;
    drive(4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 4'h2, 4'hF);
    tick();
    tests++;
    if ({out_valid64, out_valE64, cc64} !== {1'b1, 64'h8000_0000_0000_0000, 3'b011}) begin
      fails++;
      $display("FAIL add_overflow: valid=%b valE=%h cc=%b, required 1 8000000000000000 011", out_valid64, out_valE64, cc64);
    end
  endtask

  task automatic test_sub_then_jxx();
    drive(4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 4'h2, 4'hF);
    tick();
    tests++;
    if ({out_valid64, out_valE64, cc64} !== {1'b1, 64'd0, 3'b100}) begin
      fails++;
      $display("FAIL sub_equal: valid=%b valE=%h cc=%b, required 1 0 100", out_valid64, out_valE64, cc64);
    end
    drive(4'h7, 4'h3, 64'd0, 64'd0, 64'h40, 4'hF, 4'hF);
    tick();
    tests++;
    if ({out_valid64, out_icode64, out_cnd64, out_valE64} !== {1'b1, 4'h7, 1'b1, 64'd0}) begin
      fails++;
      $display("FAIL jxx_b2b: valid=%b icode=%h cnd=%b valE=%h, required 1 7 1 0", out_valid64, out_icode64, out_cnd64, out_valE64);
    end
  endtask

  task automatic test_cmov();
    drive(4'h6, 4'h1, 64'd1, 64'd0, 64'd0, 4'h2, 4'hF);
    tick();
    tests++;
    if (cc64 !== 3'b010) begin
      fails++;
      $display("FAIL cmov_setup_cc: cc=%b, required 010", cc64);
    end
    drive(4'h2, 4'h5, 64'h1234, 64'd0, 64'd0, 4'h3, 4'hF);
    tick();
    tests++;
    if ({out_cnd64, out_dstE64, out_valE64, cc64} !== {1'b0, 4'hF, 64'h1234, 3'b010}) begin
      fails++;
      $display("FAIL cmov_ge: cnd=%b dstE=%h valE=%h cc=%b, required 0 F 1234 010", out_cnd64, out_dstE64, out_valE64, cc64);
    end
  endtask

  task automatic test_stall();
    out_ready = 1'b1; in_valid = 1'b1;
    drive(4'hA, 4'h0, 64'h9, 64'h100, 64'd0, 4'h4, 4'hF);
    tick();
    tests++;
    if ({out_valid64, out_valE64} !== {1'b1, 64'hF8}) begin
      fails++;
      $display("FAIL push_accept: valid=%b valE=%h, required 1 f8", out_valid64, out_valE64);
    end
    out_ready = 1'b0;
    drive(4'h6, 4'h0, 64'd1, 64'd2, 64'd0, 4'h5, 4'hF);
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if (in_ready64 !== 1'b0) begin
        fails++;
        $display("FAIL stall_ready[%0d]: in_ready=%b, required 0", i, in_ready64);
      end
      tick();
      tests++;
      if ({out_valid64, out_icode64, out_valE64, out_dstE64, cc64} !== {1'b1, 4'hA, 64'hF8, 4'h4, 3'b010}) begin
        fails++;
        $display("FAIL stall_hold[%0d]: valid=%b icode=%h valE=%h dstE=%h cc=%b, required 1 a f8 4 010",
                 i, out_valid64, out_icode64, out_valE64, out_dstE64, cc64);
      end
    end
    out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready64 !== 1'b1) begin
      fails++;
      $display("FAIL stall_release_ready: in_ready=%b, required 1", in_ready64);
    end
    tick();
    tests++;
    if ({out_valid64, out_icode64, out_valE64, cc64} !== {1'b1, 4'h6, 64'd3, 3'b000}) begin
      fails++;
      $display("FAIL stall_release: valid=%b icode=%h valE=%h cc=%b, required 1 6 3 000", out_valid64, out_icode64, out_valE64, cc64);
    end
  endtask

  task automatic test_err();
    drive(4'hC, 4'h0, 64'h11, 64'h22, 64'h33, 4'h5, 4'h6);
    tick();
    tests++;
    if ({out_err64, out_valE64, out_dstE64, out_cnd64, out_dstM64, cc64} !== {1'b1, 64'd0, 4'hF, 1'b0, 4'h6, 3'b000}) begin
      fails++;
      $display("FAIL err_icode: err=%b valE=%h dstE=%h cnd=%b dstM=%h cc=%b, required 1 0 F 0 6 000",
               out_err64, out_valE64, out_dstE64, out_cnd64, out_dstM64, cc64);
    end
    drive(4'h6, 4'h4, 64'd0, 64'd0, 64'd0, 4'h5, 4'hF);
    tick();
    tests++;
    if ({out_err64, out_valE64, out_dstE64, cc64} !== {1'b1, 64'd0, 4'hF, 3'b000}) begin
      fails++;
      $display("FAIL err_opq_ifun: err=%b valE=%h dstE=%h cc=%b, required 1 0 F 000", out_err64, out_valE64, out_dstE64, cc64);
    end
    drive(4'h7, 4'h7, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
    tick();
    tests++;
    if ({out_err64, out_cnd64} !== {1'b1, 1'b0}) begin
      fails++;
      $display("FAIL err_jxx_ifun: err=%b cnd=%b, required 1 0", out_err64, out_cnd64);
    end
  endtask

  task automatic test_reset_mid_stall();
    out_ready = 1'b1; in_valid = 1'b1;
    drive(4'h3, 4'h0, 64'd0, 64'd0, 64'h55, 4'h1, 4'hF);
    tick();
    out_ready = 1'b0; in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    tests++;
    if ({out_valid64, out_valE64, out_icode64, cc64} !== {1'b0, 64'd0, 4'h1, 3'b100}) begin
      fails++;
      $display("FAIL reset_mid_stall: valid=%b valE=%h icode=%h cc=%b, required 0 0 1 100", out_valid64, out_valE64, out_icode64, cc64);
    end
    rst_n = 1'b1; in_valid = 1'b1;
    drive(4'h3, 4'h0, 64'd0, 64'd0, 64'h77, 4'h1, 4'hF);
    tick();
    tests++;
    if ({out_valid64, out_valE64} !== {1'b1, 64'h77}) begin
      fails++;
      $display("FAIL accept_after_reset: valid=%b valE=%h, required 1 77", out_valid64, out_valE64);
    end
    in_valid = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_w32_flush();
    do_reset();
    in_valid = 1'b1;
    drive(4'h8, 4'h0, 64'd0, 64'h10, 64'd0, 4'h4, 4'hF);
    tick();
    tests++;
    if ({out_valid32, out_valE32, out_valE64} !== {1'b1, 32'h0C, 64'h08}) begin
      fails++;
      $display("FAIL call_w32: valid=%b valE32=%h valE64=%h, required 1 0000000c 8", out_valid32, out_valE32, out_valE64);
    end
    flush = 1'b1;
    drive(4'h6, 4'h1, 64'd1, 64'd0, 64'd0, 4'h2, 4'hF);
    #1;
    tests++;
    if ({in_ready32, in_ready64} !== 2'b11) begin
      fails++;
      $display("FAIL flush_ready: in_ready32=%b in_ready64=%b, required 1 1", in_ready32, in_ready64);
    end
    tick();
    tests++;
    if ({out_valid32, out_valid64, cc32, cc64} !== {2'b00, 3'b100, 3'b100}) begin
      fails++;
      $display("FAIL flush: valid32=%b valid64=%b cc32=%b cc64=%b, required 0 0 100 100", out_valid32, out_valid64, cc32, cc64);
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_random();
    logic ev;
    logic [2:0] mcc64, mcc32;
    out_t h64, h32, got64, got32;
    exp_t e;
    logic [3:0] ic, fn;
    int k;
    do_reset();
    ev = 1'b0; mcc64 = 3'b100; mcc32 = 3'b100; h64 = '0; h32 = '0;
    for (int n = 0; n < 400; n++) begin
      k = $urandom_range(0, 9);
      ic = (k < 3) ? 4'h6 : (k < 5) ? ($urandom_range(0, 1) ? 4'h2 : 4'h7) : 4'($urandom_range(0, 15));
      fn = (ic == 4'h6 && $urandom_range(0, 7) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 7));
      drive(ic, fn, rand_op(), rand_op(), rand_op(), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      #1;
      tests++;
      if ({in_ready64, in_ready32} !== {2{!ev || out_ready}}) begin
        fails++;
        $display("FAIL rnd_ready[%0d]: in_ready64=%b in_ready32=%b, required %b", n, in_ready64, in_ready32, !ev || out_ready);
      end
      if (flush) begin
        ev = 1'b0;
      end else if (in_valid && (!ev || out_ready)) begin
        e = model(64, icode, ifun, valA, valB, valC, dstE, dstM, mcc64);
        h64 = e.o; mcc64 = e.cc;
        e = model(32, icode, ifun, valA, valB, valC, dstE, dstM, mcc32);
        h32 = e.o; mcc32 = e.cc;
        ev = 1'b1;
      end else if (out_ready) begin
        ev = 1'b0;
      end
      tick();
      tests++;
      if ({out_valid64, out_valid32, cc64, cc32} !== {ev, ev, mcc64, mcc32}) begin
        fails++;
        $display("FAIL rnd_state[%0d]: valid64=%b valid32=%b cc64=%b cc32=%b, required %b %b %b %b",
                 n, out_valid64, out_valid32, cc64, cc32, ev, ev, mcc64, mcc32);
      end
      if (ev) begin
        got64 = {out_icode64, out_valE64, out_valA64, out_dstE64, out_dstM64, out_cnd64, out_err64};
        got32 = {out_icode32, 32'd0, out_valE32, 32'd0, out_valA32, out_dstE32, out_dstM32, out_cnd32, out_err32};
        tests++;
        if (got64 !== h64) begin
          fails++;
          $display("FAIL rnd_out64[%0d]: got icode/valE/valA/dstE/dstM/cnd/err=%h, required %h", n, got64, h64);
        end
        tests++;
        if (got32 !== h32) begin
          fails++;
          $display("FAIL rnd_out32[%0d]: got icode/valE/valA/dstE/dstM/cnd/err=%h, required %h", n, got32, h32);
        end
      end
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
    test_reset();
    test_add_overflow();
    test_sub_then_jxx();
    test_cmov();
    test_stall();
    test_err();
    test_reset_mid_stall();
    test_w32_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_execute.md
PIPE_EXECUTE -- requirements
Module: pipe_execute

Interface
REQ-001 SHALL have parameter WIDTH, default 64, datapath width in bits; legal values 16, 32, 64.
REQ-002 SHALL have parameter CC_RESET, default 3'b100, reset value of {zf,sf,of}.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports in_valid input 1 and in_ready output 1: upstream handshake.
REQ-006 SHALL have ports icode input 4 and ifun input 4: instruction code and function.
REQ-007 SHALL have ports valA, valB, valC  input  WIDTH  operands.
REQ-008 SHALL have ports dstE, dstM  input  4  destination register IDs; 4'hF means none.
REQ-009 SHALL have port flush  input  1  discards the held result and blocks acceptance.
REQ-010 SHALL have ports out_valid output 1 and out_ready input 1: downstream handshake.
REQ-011 SHALL have outputs out_icode 4, out_valE WIDTH, out_valA WIDTH, out_dstE 4, out_dstM 4, out_cnd 1, out_err 1.
REQ-012 SHALL have output cc  3  current {zf,sf,of} register.

Function
REQ-013 SHALL drive in_ready = !out_valid || out_ready; it SHALL be combinational, with flush not gating it.
REQ-014 SHALL accept on an edge where in_valid && in_ready && !flush; outputs update on that edge, for a latency of 1 cycle.
REQ-015 SHALL hold every out_* stable while out_valid && !out_ready.
REQ-016 SHALL clear out_valid on an edge where out_ready is high and no accept occurs.
REQ-017 SHALL compute valE per icode: 0/1 (halt/nop) -> 0; 2 (rrmov/cmov) -> valA; 3 -> valC; 4/5 -> valB+valC; 8/A (call/push) -> valB-WIDTH/8; 9/B (ret/pop) -> valB+WIDTH/8; 7 -> 0.
REQ-018 SHALL compute OPq (icode 6) valE by ifun: 0 valB+valA, 1 valB-valA, 2 valB&valA, 3 valB^valA; all arithmetic is modulo 2^WIDTH.
REQ-019 SHALL compute zf = (res==0) and sf = res[WIDTH-1] for OPq.
REQ-020 SHALL compute of for add as sign(A)==sign(B) && sign(res)!=sign(B).
REQ-021 SHALL compute of for sub as sign(A)!=sign(B) && sign(res)!=sign(B).
REQ-022 SHALL compute of = 0 for and/xor.
REQ-023 SHALL write the cc register only on an accepted, non-error OPq; cc holds otherwise, including during stalls.
REQ-024 SHALL evaluate out_cnd for icode 2 and 7 from the cc register value before the accepting edge, by ifun: 0 always, 1 le (sf^of)|zf, 2 l sf^of, 3 e zf, 4 ne !zf, 5 ge !(sf^of), 6 g !(sf^of)&!zf.
REQ-025 SHALL set out_cnd = 0 for all other icodes.
REQ-026 SHALL make back-to-back OPq then jxx use the cc value written by that OPq.
REQ-027 SHALL set out_dstE = 4'hF for icode 2 with cnd=0; otherwise out_dstE = dstE.
REQ-028 SHALL pass out_dstM, out_valA and out_icode through unchanged.
REQ-029 SHALL set out_err = 1 for icode > 4'hB, OPq ifun > 3, or icode 2/7 with ifun > 6.
REQ-030 SHALL make an error instruction produce valE = 0, cnd = 0, out_dstE = 4'hF and no cc update.
REQ-031 SHALL give flush priority over everything: on a flush edge out_valid -> 0, no accept, no cc update.

Reset
REQ-032 SHALL, on an edge with rst_n=0, set out_valid=0, out_valE/out_valA=0, out_icode=1 (nop), out_dstE/out_dstM=4'hF, out_cnd=0, out_err=0 and cc=CC_RESET.
REQ-033 SHALL, on reset mid-stall, drop the held result; the first accept is possible on the first edge with rst_n=1.

Structure
REQ-034 SHALL place the icode/ifun constants, RNONE=4'hF, cc bit indices and CC_RESET default in shared package y86_pkg.
REQ-035 SHALL place condition evaluation (cc, ifun -> cnd) in combinational sub-module y86_cond, instantiated once.
REQ-036 SHALL contain ALU, cc register and output register in pipe_execute.

Verification
REQ-037 Bench SHALL cover: WIDTH=64, reset, OPq add with valA=1, valB=7FFF_FFFF_FFFF_FFFF -> valE=8000_0000_0000_0000 and cc=3'b011 next edge.
REQ-038 Bench SHALL cover: OPq sub with valA=5, valB=5, then jxx ifun=3 back-to-back -> first valE=0 and cc=3'b100; second out_cnd=1.
REQ-039 Bench SHALL cover: cc=3'b010, cmov ifun=5, dstE=3 -> out_cnd=0, out_dstE=4'hF, out_valE=valA.
REQ-040 Bench SHALL cover: out_ready=0 for 3 cycles with pushq valB=0x100 held and in_valid high -> in_ready=0, outputs stable at valE=0xF8, cc unchanged; first edge with out_ready=1 accepts next.
REQ-041 Bench SHALL cover: icode=4'hC and, separately, OPq ifun=4 -> out_err=1, valE=0, cc unchanged.
REQ-042 Bench SHALL cover: WIDTH=32, call valB=0x10 -> valE=0x0C; flush and in_valid on the same edge -> out_valid=0, no cc change.
